// File: rtl/full_adder_slice.sv
// rtl/full_adder_slice.sv - 1-bit full adder slice with combinational ripple outputs and an optional registered copy
// Optional macro FA_GEN_PROP_EN adds the o_gen/o_prop carry-lookahead ports.
module full_adder_slice #(
  parameter int OUT_REG = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  logic i_in_valid,
  output logic o_sum,
  output logic o_cout,
  output logic o_sum_q,
  output logic o_cout_q,
  output logic o_out_valid
`ifdef FA_GEN_PROP_EN
  ,
  output logic o_gen,
  output logic o_prop
`endif
);

  logic w_gen;
  logic w_prop;

  assign w_gen  = i_a & i_b;
  assign w_prop = i_a ^ i_b;
  assign o_sum  = w_prop ^ i_cin;
  assign o_cout = w_gen | (i_cin & w_prop);

`ifdef FA_GEN_PROP_EN
  assign o_gen  = w_gen;
  assign o_prop = w_prop;
`endif

  generate
    if (OUT_REG != 0) begin : g_reg
      logic r_sum;
      logic r_cout;
      logic r_valid;

      // Data flops only load on a valid beat so the last result stays visible.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_sum   <= 1'b0;
          r_cout  <= 1'b0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= i_in_valid;
          if (i_in_valid) begin
            r_sum  <= o_sum;
            r_cout <= o_cout;
          end
        end
      end

      assign o_sum_q     = r_sum;
      assign o_cout_q    = r_cout;
      assign o_out_valid = r_valid;
    end else begin : g_comb
      assign o_sum_q     = o_sum;
      assign o_cout_q    = o_cout;
      assign o_out_valid = i_in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_slice.sv
// tb/tb_full_adder_slice.sv - directed self-checking bench for full_adder_slice
module tb_full_adder_slice;

  logic clk;
  logic rst_n;
  logic a, b, cin, in_valid;
  logic sum, cout, sum_q, cout_q, out_valid;
  logic m_sum, m_cout, m_sum_q, m_cout_q, m_out_valid;
`ifdef FA_GEN_PROP_EN
  logic gen, prop, m_gen, m_prop;
  logic [3:0] rc_gen, rc_prop;
`endif

  logic [3:0] ra, rb;
  logic       addsub;
  logic [3:0] rb_x;
  logic [4:0] rc;
  logic [3:0] rs, rs_q, rc_q, rv_q;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] EXP_TBL [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  full_adder_slice #(.OUT_REG(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_cin(cin), .i_in_valid(in_valid),
    .o_sum(sum), .o_cout(cout), .o_sum_q(sum_q), .o_cout_q(cout_q), .o_out_valid(out_valid)
`ifdef FA_GEN_PROP_EN
    , .o_gen(gen), .o_prop(prop)
`endif
  );

  full_adder_slice #(.OUT_REG(0)) u_dut_comb (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_cin(cin), .i_in_valid(in_valid),
    .o_sum(m_sum), .o_cout(m_cout), .o_sum_q(m_sum_q), .o_cout_q(m_cout_q), .o_out_valid(m_out_valid)
`ifdef FA_GEN_PROP_EN
    , .o_gen(m_gen), .o_prop(m_prop)
`endif
  );

  assign rb_x  = rb ^ {4{addsub}};
  assign rc[0] = addsub;

  for (genvar g = 0; g < 4; g++) begin : g_ripple
    full_adder_slice #(.OUT_REG(0)) u_slice (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(ra[g]), .i_b(rb_x[g]), .i_cin(rc[g]), .i_in_valid(1'b0),
      .o_sum(rs[g]), .o_cout(rc[g+1]), .o_sum_q(rs_q[g]), .o_cout_q(rc_q[g]), .o_out_valid(rv_q[g])
`ifdef FA_GEN_PROP_EN
      , .o_gen(rc_gen[g]), .o_prop(rc_prop[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [2:0]  v;
    logic [1:0]  e;
    rst_n = 1'b1; a = 0; b = 0; cin = 0; in_valid = 0;
    ra = 0; rb = 0; addsub = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_sum_q", {7'd0, sum_q}, 8'd0);
    check("rst_cout_q", {7'd0, cout_q}, 8'd0);
    check("rst_valid", {7'd0, out_valid}, 8'd0);

    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = i[2:0];
      {a, b, cin} = v;
      in_valid = v[0];
      #1;
      check($sformatf("comb_%0d", i), {6'd0, cout, sum}, {6'd0, EXP_TBL[i]});
      check($sformatf("mirror_%0d", i), {5'd0, m_cout_q, m_sum_q, m_out_valid},
            {5'd0, EXP_TBL[i], v[0]});
    end

    @(negedge clk) {a, b, cin} = 3'b110; in_valid = 1'b1;
    @(posedge clk) #1;
    check("lat_q", {5'd0, out_valid, cout_q, sum_q}, 8'b0000_0110);
    @(negedge clk) {a, b, cin} = 3'b001; in_valid = 1'b0;
    @(posedge clk) #1;
    check("hold_q", {5'd0, out_valid, cout_q, sum_q}, 8'b0000_0010);

    @(negedge clk) {a, b, cin} = 3'b100; in_valid = 1'b1;
    @(posedge clk) #1;
    check("pre_rst_q", {5'd0, out_valid, cout_q, sum_q}, 8'b0000_0101);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", {5'd0, out_valid, cout_q, sum_q}, 8'b0000_0000);
    @(negedge clk) rst_n = 1'b1; {a, b, cin} = 3'b011; in_valid = 1'b1;
    @(posedge clk) #1;
    check("first_cap_q", {5'd0, out_valid, cout_q, sum_q}, 8'b0000_0110);

    ra = 4'd5; rb = 4'd3; addsub = 1'b1; #1;
    check("ripple_sub", {3'd0, rc[4], rs}, 8'b0001_0010);
    addsub = 1'b0; #1;
    check("ripple_add", {3'd0, rc[4], rs}, 8'b0000_1000);
    ra = 4'd15; rb = 4'd1; #1;
    check("ripple_wrap", {3'd0, rc[4], rs}, 8'b0001_0000);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      e = 2'(a) + 2'(b) + 2'(cin);
      @(posedge clk) #1;
      check($sformatf("stream_%0d", i), {5'd0, out_valid, cout_q, sum_q}, {5'd0, 1'b1, e});
    end
    @(negedge clk) in_valid = 1'b0;

`ifdef FA_GEN_PROP_EN
    a = 1'b1; b = 1'b1; #1;
    check("gp_11", {6'd0, gen, prop}, 8'b0000_0010);
    a = 1'b1; b = 1'b0; #1;
    check("gp_10", {6'd0, gen, prop}, 8'b0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
